dmem_load_align: RTL and testbench

DMEM_LOAD_ALIGN -- requirements
Module: dmem_load_align

---
 rtl/dmem_load_align_pkg.sv | 49 ++++
 rtl/dmem_load_align_extract.sv | 47 ++++
 rtl/dmem_load_align.sv | 134 +++++++++++++
 tb/tb_dmem_load_align.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_load_align_pkg.sv
// ---------------------------------------------------------------------------
// dmem_load_align_pkg
// Shared CPU definitions for the data-memory load path:
//   - FSM state encoding of the load aligner (IDLE, READ, DATA, DONE, ERR)
//   - access size codes (BYTE / HALF / WORD)
//   - big-endian byte-lane offsets and byte-enable masks. The store-side
//     address/enable block uses the same masks, so loads and stores agree
//     on which lane an address offset selects.
//   - sizeCode(): turns the Do_Byte / Do_Half decode into a size code
// ---------------------------------------------------------------------------
package dmem_load_align_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Address offset -> byte lane, big-endian (offset 0 is the top byte)
  localparam logic [1:0] LANE_OFS_31_24 = 2'd0;
  localparam logic [1:0] LANE_OFS_23_16 = 2'd1;
  localparam logic [1:0] LANE_OFS_15_8  = 2'd2;
  localparam logic [1:0] LANE_OFS_7_0   = 2'd3;

  // Byte-enable masks matching the lane offsets above
  localparam logic [3:0] BYTE_EN_LANE0 = 4'b1000;
  localparam logic [3:0] BYTE_EN_LANE1 = 4'b0100;
  localparam logic [3:0] BYTE_EN_LANE2 = 4'b0010;
  localparam logic [3:0] BYTE_EN_LANE3 = 4'b0001;
  localparam logic [3:0] HALF_EN_HI    = 4'b1100;
  localparam logic [3:0] HALF_EN_LO    = 4'b0011;
  localparam logic [3:0] WORD_EN       = 4'b1111;

  // Byte takes priority, so Do_Byte and Do_Half both set is a byte access
  function automatic logic [1:0] sizeCode(input logic doByte, input logic doHalf);
    if (doByte) begin
      return SIZE_BYTE;
    end else if (doHalf) begin
      return SIZE_HALF;
    end else begin
      return SIZE_WORD;
    end
  endfunction

endpackage

// File: rtl/dmem_load_align_extract.sv
// ---------------------------------------------------------------------------
// load_extract
// Combinational lane select and sign/zero extension of a loaded word.
// Ports:
//   word   [31:0] in  : raw word read from data memory
//   offset [1:0]  in  : byte offset of the load inside the word
//   size   [1:0]  in  : SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   sign          in  : 1 = sign-extend, 0 = zero-extend (ignored for words)
//   result [31:0] out : aligned, extended load value
// ---------------------------------------------------------------------------
module load_extract
  import dmem_load_align_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword out of the big-endian word, then
  // widen according to the access size. Halfwords only look at offset[1],
  // so an odd halfword offset naturally rounds down to the even lane.
  always_comb begin
    w_byte = word[7:0];
    case (offset)
      LANE_OFS_31_24: w_byte = word[31:24];
      LANE_OFS_23_16: w_byte = word[23:16];
      LANE_OFS_15_8:  w_byte = word[15:8];
      LANE_OFS_7_0:   w_byte = word[7:0];
      default:        w_byte = word[7:0];
    endcase

    w_half = offset[1] ? word[15:0] : word[31:16];

    result = word;
    case (size)
      SIZE_BYTE: result = {{24{sign & w_byte[7]}}, w_byte};
      SIZE_HALF: result = {{16{sign & w_half[15]}}, w_half};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/dmem_load_align.sv
// ---------------------------------------------------------------------------
// dmem_load_align
// Load sequencer between the CPU and data memory: presents the word
// address, waits one cycle for the read data, extracts/extends the
// addressed byte/halfword/word and pulses load_valid.
// Sequence: IDLE -> READ -> DATA -> DONE -> IDLE (request-to-valid = 3).
// Ports:
//   clock, resetn (async, active-low)
//   load_req, Do_Byte, Do_Half, Sign_Ext, Address_in[31:0] : request side
//   mem_rdata[31:0] in / Address_out[31:0] out             : memory side
//   load_busy, load_valid, load_data[31:0], misalign       : status/result
// Configuration:
//   DMEM_LOAD_MISALIGN_TRAP_EN : when defined, a halfword at an odd offset
//   or a word at a nonzero offset goes IDLE -> ERR -> IDLE and pulses
//   misalign instead of loading. When undefined there is no ERR state,
//   misalign stays 0 and every load completes.
// ---------------------------------------------------------------------------
module dmem_load_align
  import dmem_load_align_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        load_req,
  input  logic        Do_Byte,
  input  logic        Do_Half,
  input  logic        Sign_Ext,
  input  logic [31:0] Address_in,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Address_out,
  output logic        load_busy,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [2:0]  r_state;
  logic [31:0] r_addrOut;
  logic [1:0]  r_offset;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [31:0] r_loadData;
  logic        r_loadValid;
  logic        r_misalign;

  logic [1:0]  w_reqSize;
  logic [31:0] w_extracted;

  assign w_reqSize = sizeCode(Do_Byte, Do_Half);

`ifdef DMEM_LOAD_MISALIGN_TRAP_EN
  logic w_reqMisaligned;

  // A halfword must sit on an even offset and a word on offset zero
  assign w_reqMisaligned = ((w_reqSize == SIZE_HALF) && Address_in[0]) ||
                           ((w_reqSize == SIZE_WORD) && (Address_in[1:0] != 2'b00));
`endif

  // The extractor works on the latched request; its result is only
  // captured while the FSM sits in DATA, when mem_rdata is valid.
  load_extract u_extract (
    .word   (mem_rdata),
    .offset (r_offset),
    .size   (r_size),
    .sign   (r_sign),
    .result (w_extracted)
  );

  // Main load FSM. load_valid and misalign are registered pulses that are
  // cleared every cycle and set only on the transition into DONE / ERR, so
  // each lasts exactly one cycle. Requests are only looked at in IDLE,
  // which is what drops load_req while busy without queuing it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_addrOut   <= 32'h0;
      r_offset    <= 2'b00;
      r_size      <= SIZE_WORD;
      r_sign      <= 1'b0;
      r_loadData  <= 32'h0;
      r_loadValid <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_loadValid <= 1'b0;
      r_misalign  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_req) begin
            r_offset <= Address_in[1:0];
            r_size   <= w_reqSize;
            r_sign   <= Sign_Ext;
`ifdef DMEM_LOAD_MISALIGN_TRAP_EN
            if (w_reqMisaligned) begin
              r_misalign <= 1'b1;
              r_state    <= ST_ERR;
            end else begin
              r_addrOut <= {Address_in[31:2], 2'b00};
              r_state   <= ST_READ;
            end
`else
            r_addrOut <= {Address_in[31:2], 2'b00};
            r_state   <= ST_READ;
`endif
          end
        end
        ST_READ: begin
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_loadData  <= w_extracted;
          r_loadValid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
`ifdef DMEM_LOAD_MISALIGN_TRAP_EN
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Address_out = r_addrOut;
  assign load_busy   = (r_state != ST_IDLE);
  assign load_valid  = r_loadValid;
  assign load_data   = r_loadData;
  assign misalign    = r_misalign;

endmodule

// File: tb/tb_dmem_load_align.sv
// ---------------------------------------------------------------------------
// tb_dmem_load_align
// Directed bench for dmem_load_align. Expected values are hand-computed
// from the big-endian lane mapping and the 3-cycle request-to-valid timing.
// Honours DMEM_LOAD_MISALIGN_TRAP_EN for the misaligned-halfword step.
// ---------------------------------------------------------------------------
module tb_dmem_load_align;

  logic        clock;
  logic        resetn;
  logic        load_req;
  logic        Do_Byte;
  logic        Do_Half;
  logic        Sign_Ext;
  logic [31:0] Address_in;
  logic [31:0] mem_rdata;
  logic [31:0] Address_out;
  logic        load_busy;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign;

  int vectorCount = 0;
  int missCount   = 0;
  int validCount  = 0;
  int misalignCount = 0;

  dmem_load_align dut (
    .clock       (clock),
    .resetn      (resetn),
    .load_req    (load_req),
    .Do_Byte     (Do_Byte),
    .Do_Half     (Do_Half),
    .Sign_Ext    (Sign_Ext),
    .Address_in  (Address_in),
    .mem_rdata   (mem_rdata),
    .Address_out (Address_out),
    .load_busy   (load_busy),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .misalign    (misalign)
  );

  // 10 ns free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Tally completion and trap pulses, sampled mid-cycle
  always @(negedge clock) begin
    if (load_valid) validCount++;
    if (misalign) misalignCount++;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic req, input logic b, input logic h,
                               input logic s, input logic [31:0] addr,
                               input logic [31:0] word);
    load_req   = req;
    Do_Byte    = b;
    Do_Half    = h;
    Sign_Ext   = s;
    Address_in = addr;
    mem_rdata  = word;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one load from just after a rising edge with the DUT in IDLE and
  // follow it through READ, DATA and DONE; returns just after the edge that
  // brings the DUT back to IDLE.
  task automatic doLoad(input string tag, input logic b, input logic h,
                        input logic s, input logic [31:0] addr,
                        input logic [31:0] word, input logic [31:0] expData);
    applyStimulus(1'b1, b, h, s, addr, word);
    @(posedge clock); #1;
    load_req = 1'b0;
    @(negedge clock);
    checkOutput({tag, "_busy1"}, {31'b0, load_busy}, 32'd1);
    checkOutput({tag, "_valid1"}, {31'b0, load_valid}, 32'd0);
    checkOutput({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
    checkOutput({tag, "_addr"}, Address_out, {addr[31:2], 2'b00});
    @(posedge clock); @(negedge clock);
    checkOutput({tag, "_valid2"}, {31'b0, load_valid}, 32'd0);
    @(posedge clock); @(negedge clock);
    checkOutput({tag, "_valid3"}, {31'b0, load_valid}, 32'd1);
    checkOutput({tag, "_data"}, load_data, expData);
    @(posedge clock); #1;
    checkOutput({tag, "_idle"}, {31'b0, load_busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] savedData;
    logic [31:0] savedAddr;
    int savedValid;
    logic [9:0] pattern;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    resetn = 1'b0;
    #2;
    checkOutput("rst_addr", Address_out, 32'h0);
    checkOutput("rst_data", load_data, 32'h0);
    checkOutput("rst_valid", {31'b0, load_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, load_busy}, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;

    // Lane select and extension on 0x8899AABB
    doLoad("lb_10",  1'b1, 1'b0, 1'b1, 32'h10, 32'h8899AABB, 32'hFFFFFF88);
    doLoad("lbu_13", 1'b1, 1'b0, 1'b0, 32'h13, 32'h8899AABB, 32'h000000BB);
    doLoad("lh_12",  1'b0, 1'b1, 1'b1, 32'h12, 32'h8899AABB, 32'hFFFFAABB);
    doLoad("lhu_10", 1'b0, 1'b1, 1'b0, 32'h10, 32'h8899AABB, 32'h00008899);
    doLoad("lb_11",  1'b1, 1'b0, 1'b1, 32'h11, 32'h8899AABB, 32'hFFFFFF99);
    doLoad("lbu_12", 1'b1, 1'b0, 1'b0, 32'h12, 32'h8899AABB, 32'h000000AA);
    doLoad("bh_13",  1'b1, 1'b1, 1'b1, 32'h13, 32'h8899AABB, 32'hFFFFFFBB);
    doLoad("lh_pos", 1'b0, 1'b1, 1'b1, 32'h40, 32'h7F001234, 32'h00007F00);
    doLoad("lb_pos", 1'b1, 1'b0, 1'b1, 32'h43, 32'h7F001234, 32'h00000034);
    doLoad("lw_sx",  1'b0, 1'b0, 1'b1, 32'h80, 32'h80000001, 32'h80000001);

    // lw followed immediately by a second request in the next IDLE cycle
    savedValid = validCount;
    doLoad("lw_24", 1'b0, 1'b0, 1'b0, 32'h24, 32'h12345678, 32'h12345678);
    doLoad("lw_b2b", 1'b0, 1'b0, 1'b0, 32'h28, 32'hCAFEF00D, 32'hCAFEF00D);
    checkOutput("b2b_count", validCount - savedValid, 32'd2);

    // Halfword at an odd offset
`ifdef DMEM_LOAD_MISALIGN_TRAP_EN
    savedData  = load_data;
    savedAddr  = Address_out;
    savedValid = validCount;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 32'h8899AABB);
    @(posedge clock); #1;
    load_req = 1'b0;
    @(negedge clock);
    checkOutput("trap_misalign1", {31'b0, misalign}, 32'd1);
    checkOutput("trap_busy1", {31'b0, load_busy}, 32'd1);
    checkOutput("trap_addr", Address_out, savedAddr);
    @(posedge clock); @(negedge clock);
    checkOutput("trap_misalign2", {31'b0, misalign}, 32'd0);
    checkOutput("trap_busy2", {31'b0, load_busy}, 32'd0);
    repeat (4) @(negedge clock);
    checkOutput("trap_data", load_data, savedData);
    checkOutput("trap_novalid", validCount - savedValid, 32'd0);
    checkOutput("trap_pulses", misalignCount, 32'd1);
    @(posedge clock); #1;
`else
    doLoad("lh_11", 1'b0, 1'b1, 1'b1, 32'h11, 32'h8899AABB, 32'hFFFF8899);
    doLoad("lw_26", 1'b0, 1'b0, 1'b0, 32'h26, 32'h0A0B0C0D, 32'h0A0B0C0D);
    checkOutput("notrap_pulses", misalignCount, 32'd0);
`endif

    // Reset dropped while the load sits in DATA
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h11223344);
    @(posedge clock); #1;
    load_req = 1'b0;
    @(posedge clock); #3;
    resetn = 1'b0;
    #1;
    checkOutput("midrst_addr", Address_out, 32'h0);
    checkOutput("midrst_data", load_data, 32'h0);
    checkOutput("midrst_valid", {31'b0, load_valid}, 32'd0);
    checkOutput("midrst_busy", {31'b0, load_busy}, 32'd0);
    checkOutput("midrst_misalign", {31'b0, misalign}, 32'd0);
    savedValid = validCount;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("midrst_novalid", validCount - savedValid, 32'd0);
    @(posedge clock); #1;
    doLoad("after_rst", 1'b0, 1'b1, 1'b0, 32'h22, 32'h11223344, 32'h00003344);

    // load_req held for six cycles: completions in cycles 3 and 7 only
    pattern = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0BADBEEF);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      pattern[c] = load_valid;
      @(posedge clock); #1;
      if (c == 5) load_req = 1'b0;
    end
    checkOutput("held_req_pattern", {22'b0, pattern}, 32'h088);
    checkOutput("held_req_data", load_data, 32'h0BADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
